// File: rtl/mdu_hilo_if.sv
// Operand, control and result bundle between the E-stage datapath and the HI/LO multiply/divide unit.
interface mdu_hilo_if;
  logic        start;
  logic [3:0]  hilo_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  modport master (
    output start, hilo_op, src_a, src_b, cancel,
    input  busy, hi, lo, rd_data
  );

  modport slave (
    input  start, hilo_op, src_a, src_b, cancel,
    output busy, hi, lo, rd_data
  );
endinterface

// File: rtl/mdu_hilo.sv
// E-stage multiply/divide unit holding architectural HI/LO, with fixed multicycle busy latency.
// Optional multiply-accumulate (hilo_op 9) is built when MDU_MADD_EN is defined.
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  mdu_hilo_if.slave  bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [3:0] L_MULT = 4'(MULT_CYCLES);
  localparam logic [3:0] L_DIV  = 4'(DIV_CYCLES);

  logic [0:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_hi_stg;
  logic [31:0] r_lo_stg;
  logic        r_stg_wr;

  logic        w_idle;
  logic        w_md;
  logic        w_launch;
  logic        w_res_wr;
  logic [3:0]  w_cyc;
  logic [63:0] w_res;
  logic [31:0] w_div_b;

  function automatic logic [63:0] f_mult_s(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ae;
    logic signed [63:0] be;
    ae = {{32{a[31]}}, a};
    be = {{32{b[31]}}, b};
    return ae * be;
  endfunction

  function automatic logic [63:0] f_mult_u(input logic [31:0] a, input logic [31:0] b);
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Returns {remainder, quotient}; the only signed overflow case is pinned explicitly.
  function automatic logic [63:0] f_div_s(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] q;
    logic signed [31:0] r;
    sa = a;
    sb = b;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'sh8000_0000;
      r = 32'sd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return {r, q};
  endfunction

  function automatic logic [63:0] f_div_u(input logic [31:0] a, input logic [31:0] b);
    return {a % b, a / b};
  endfunction

  assign w_idle   = (r_state == S_IDLE);
  assign w_div_b  = (bus.src_b == 32'd0) ? 32'd1 : bus.src_b;
  assign w_launch = w_idle & bus.start & ~bus.cancel & w_md;

  always_comb begin
    w_md     = 1'b0;
    w_cyc    = '0;
    w_res    = '0;
    w_res_wr = 1'b1;
    case (bus.hilo_op)
      4'd1: begin w_md = 1'b1; w_cyc = L_MULT; w_res = f_mult_s(bus.src_a, bus.src_b); end
      4'd2: begin w_md = 1'b1; w_cyc = L_MULT; w_res = f_mult_u(bus.src_a, bus.src_b); end
      4'd3: begin
        w_md = 1'b1; w_cyc = L_DIV; w_res = f_div_s(bus.src_a, w_div_b);
        w_res_wr = |bus.src_b;
      end
      4'd4: begin
        w_md = 1'b1; w_cyc = L_DIV; w_res = f_div_u(bus.src_a, w_div_b);
        w_res_wr = |bus.src_b;
      end
`ifdef MDU_MADD_EN
      4'd9: begin
        w_md = 1'b1; w_cyc = L_MULT;
        w_res = {r_hi, r_lo} + f_mult_s(bus.src_a, bus.src_b);
      end
`endif
      default: ;
    endcase
  end

  // Result is computed at launch; the counter only models the latency.
  always_ff @(posedge clk) begin
    if (w_launch) begin
      r_hi_stg <= w_res[63:32];
      r_lo_stg <= w_res[31:0];
      r_stg_wr <= w_res_wr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_launch) begin
        r_state <= S_RUN;
        r_cnt   <= w_cyc;
      end else if (!bus.cancel && bus.hilo_op == 4'd7) begin
        r_hi <= bus.src_a;
      end else if (!bus.cancel && bus.hilo_op == 4'd8) begin
        r_lo <= bus.src_a;
      end
    end else begin
      if (r_cnt <= 4'd1) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        if (r_stg_wr) begin
          r_hi <= r_hi_stg;
          r_lo <= r_lo_stg;
        end
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign bus.busy    = (r_state == S_RUN);
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.rd_data = (bus.hilo_op == 4'd5) ? r_hi :
                       (bus.hilo_op == 4'd6) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mdu_hilo.sv
// Randomized and directed bench for mdu_hilo against an arithmetic HI/LO reference model.
module tb_mdu_hilo;
  logic        clk = 1'b0;
  logic        reset_n;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  mdu_hilo_if bus ();

  mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input logic [3:0] op);
    case (op)
      4'd1, 4'd2: return 5;
      4'd3, 4'd4: return 10;
`ifdef MDU_MADD_EN
      4'd9:       return 5;
`endif
      default:    return 0;
    endcase
  endfunction

  function automatic longint absl(input longint x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    logic [63:0] p;
    case (op)
      4'd1: begin p = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = p; end
      4'd2: begin p = longint'(a) * longint'(b); {m_hi, m_lo} = p; end
      4'd3, 4'd4: begin
        if (b != 32'd0) begin
          la = (op == 4'd3) ? longint'($signed(a)) : longint'(a);
          lb = (op == 4'd3) ? longint'($signed(b)) : longint'(b);
          q = absl(la) / absl(lb);
          r = absl(la) % absl(lb);
          if ((la < 0) != (lb < 0)) q = -q;
          if (la < 0) r = -r;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
`ifdef MDU_MADD_EN
      4'd9: begin
        p = {m_hi, m_lo} + 64'(longint'($signed(a)) * longint'($signed(b)));
        {m_hi, m_lo} = p;
      end
`endif
      default: ;
    endcase
  endtask

  // Launch at a negedge; while busy, present dur_op/dur_start and scrambled operands.
  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] dur_op, input logic dur_start, input string tag);
    int n;
    int exp_n;
    exp_n = lat(op);
    bus.start   = 1'b1;
    bus.hilo_op = op;
    bus.src_a   = a;
    bus.src_b   = b;
    @(posedge clk); #1;
    bus.start   = dur_start;
    bus.hilo_op = dur_op;
    bus.src_a   = $urandom;
    bus.src_b   = $urandom;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
    bus.start   = 1'b0;
    bus.hilo_op = 4'd0;
    if (exp_n != 0) ref_md(op, a, b);
    check({tag, " busy cycles"}, 32'(n), 32'(exp_n));
    check({tag, " hi"}, bus.hi, m_hi);
    check({tag, " lo"}, bus.lo, m_lo);
  endtask

  task automatic mv(input logic [3:0] op, input logic [31:0] v);
    bus.hilo_op = op;
    bus.src_a   = v;
    @(posedge clk); #1;
    bus.hilo_op = 4'd0;
    if (op == 4'd7) m_hi = v;
    if (op == 4'd8) m_lo = v;
    @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] op, input logic [31:0] exp, input string tag);
    bus.hilo_op = op;
    #1;
    check(tag, bus.rd_data, exp);
    bus.hilo_op = 4'd0;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0]  ops [6];
    logic [3:0]  op;
    logic [31:0] a, b;
    ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};
    bus.start = 1'b0; bus.hilo_op = 4'd0; bus.src_a = '0; bus.src_b = '0; bus.cancel = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_md(4'd1, 32'hFFFF_FFFD, 32'd7, 4'd0, 1'b0, "mult -3*7");
    check("mult hi const", bus.hi, 32'hFFFF_FFFF);
    check("mult lo const", bus.lo, 32'hFFFF_FFEB);
    run_md(4'd2, 32'hFFFF_FFFD, 32'd7, 4'd0, 1'b0, "multu");
    check("multu hi const", bus.hi, 32'h0000_0006);
    check("multu lo const", bus.lo, 32'hFFFF_FFEB);
    run_md(4'd3, 32'hFFFF_FFF9, 32'd2, 4'd0, 1'b0, "div -7/2");
    check("div lo const", bus.lo, 32'hFFFF_FFFD);
    check("div hi const", bus.hi, 32'hFFFF_FFFF);
    run_md(4'd4, 32'd100, 32'd7, 4'd0, 1'b0, "divu 100/7");
    check("divu lo const", bus.lo, 32'd14);
    check("divu hi const", bus.hi, 32'd2);
    run_md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 4'd0, 1'b0, "div ovf");
    check("div ovf lo const", bus.lo, 32'h8000_0000);
    check("div ovf hi const", bus.hi, 32'd0);

    mv(4'd7, 32'h1234_5678);
    run_md(4'd4, 32'd5, 32'd0, 4'd0, 1'b0, "divu by 0");
    check("div0 hi const", bus.hi, 32'h1234_5678);
    rd(4'd5, 32'h1234_5678, "mfhi");
    rd(4'd6, m_lo, "mflo");
    rd(4'd0, 32'd0, "rd none");

    bus.cancel = 1'b1; bus.start = 1'b1; bus.hilo_op = 4'd1;
    bus.src_a = 32'd9; bus.src_b = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hilo_op = 4'd7;
    @(posedge clk); #1;
    bus.cancel = 1'b0; bus.hilo_op = 4'd0;
    @(negedge clk);
    check("cancel busy", 32'(bus.busy), 32'd0);
    check("cancel hi", bus.hi, m_hi);
    check("cancel lo", bus.lo, m_lo);

    run_md(4'd1, 32'h0001_0003, 32'h0000_0101, 4'd8, 1'b0, "mult+mtlo");
    run_md(4'd1, 32'hFFFF_0000, 32'h0002_0000, 4'd3, 1'b1, "mult+start");

`ifdef MDU_MADD_EN
    mv(4'd7, 32'd0);
    mv(4'd8, 32'hFFFF_FFFF);
    run_md(4'd9, 32'd1, 32'd1, 4'd0, 1'b0, "madd");
    check("madd hi const", bus.hi, 32'd1);
    check("madd lo const", bus.lo, 32'd0);
`else
    run_md(4'd9, 32'd1, 32'd1, 4'd0, 1'b0, "op9 noop");
`endif

    for (int k = 0; k < 24; k++) begin
      op = ops[$urandom_range(0, 5)];
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (op == 4'd7 || op == 4'd8) begin
        mv(op, a);
        check("rand mv hi", bus.hi, m_hi);
        check("rand mv lo", bus.lo, m_lo);
      end else begin
        run_md(op, a, b, 4'd0, 1'b0, "rand md");
      end
    end

    mv(4'd7, 32'hAAAA_5555);
    mv(4'd8, 32'h5555_AAAA);
    bus.start = 1'b1; bus.hilo_op = 4'd3; bus.src_a = 32'd1000; bus.src_b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hilo_op = 4'd0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    check("async rst busy", 32'(bus.busy), 32'd0);
    check("async rst hi", bus.hi, m_hi);
    check("async rst lo", bus.lo, m_lo);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post rst busy", 32'(bus.busy), 32'd0);
    check("post rst hi", bus.hi, m_hi);
    check("post rst lo", bus.lo, m_lo);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
